// File: rtl/cos_arbiter.sv
// rtl/cos_arbiter.sv - round-robin arbiter sharing one multi-cycle cos engine
module cos_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  theta_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic                   resp_err,
  output logic [31:0]            resp_data,
  output logic                   busy,
  output logic                   cos_start,
  output logic [31:0]            cos_theta,
  input  logic                   cos_done,
  input  logic [31:0]            cos_result
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [31:0]       theta_q, theta_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rerr_q, rerr_d;

  logic [IW-1:0]     winner;
  logic              found;
  logic [IW-1:0]     idx;
  logic [NUM_REQ-1:0] owner_onehot;

  // Rotating priority scan: first pending requester after the last one served
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(last_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and datapath update for the ISSUE/WAIT/RESP handshake
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    theta_d = theta_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      S_IDLE: begin
        if (clk_en && (|req)) begin
          owner_d = winner;
          theta_d = theta_in[32*winner +: 32];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tcnt_d  = '0;
        // Engine clock was gated during the start pulse, so nothing was issued
        state_d = clk_en ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        // A dropped clk_en wins over a coincident done; done wins over timeout
        if (!clk_en) begin
          rdata_d = QNAN;
          rerr_d  = 1'b1;
          last_d  = owner_q;
          state_d = S_RESP;
        end else if (cos_done) begin
          rdata_d = cos_result;
          rerr_d  = 1'b0;
          last_d  = owner_q;
          state_d = S_RESP;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          rdata_d = QNAN;
          rerr_d  = 1'b1;
          last_d  = owner_q;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset gives requester 0 first priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      tcnt_q  <= '0;
      theta_q <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      theta_q <= theta_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Outputs are decoded from state and registered owner only
  always_comb begin
    owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    grant        = (state_q != S_IDLE) ? owner_onehot : '0;
    resp_valid   = (state_q == S_RESP) ? owner_onehot : '0;
    busy         = (state_q != S_IDLE);
    cos_start    = (state_q == S_ISSUE);
    cos_theta    = theta_q;
    resp_data    = rdata_q;
    resp_err     = rerr_q;
  end

endmodule
